smart_traffic_ctrl_gen2: RTL and testbench

//  Parametrised highway/street traffic-light controller with car-sensor demand, all-red clearance,

---
 rtl/smart_traffic_ctrl_gen2_pkg.sv | 52 +++++
 rtl/smart_traffic_ctrl_gen2_seg7.sv | 27 ++
 rtl/smart_traffic_ctrl_gen2.sv | 214 +++++++++++++++++++++
 tb/tb_smart_traffic_ctrl_gen2.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/smart_traffic_ctrl_gen2_pkg.sv
// Package tlc_pkg: shared types and constants for the highway/street traffic
// light controller.
//   phase_t     - controller phases, in sequence order
//   lamps_t     - the six lamp drives, highway first
//   SEG_*       - 7-segment patterns {g,f,e,d,c,b,a}, active-high
//   phase_lamps - Moore lamp decode for a phase
package tlc_pkg;

  typedef enum logic [2:0] {
    HW_GREEN,
    HW_YELLOW,
    AR1,
    ST_GREEN,
    ST_YELLOW,
    AR2
  } phase_t;

  typedef struct packed {
    logic red_hw;
    logic yellow_hw;
    logic green_hw;
    logic red_st;
    logic yellow_st;
    logic green_st;
  } lamps_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic lamps_t phase_lamps(input phase_t p);
    lamps_t l;
    l = '0;
    case (p)
      HW_GREEN:  begin l.green_hw = 1'b1; l.red_st    = 1'b1; end
      HW_YELLOW: begin l.yellow_hw = 1'b1; l.red_st   = 1'b1; end
      ST_GREEN:  begin l.red_hw   = 1'b1; l.green_st  = 1'b1; end
      ST_YELLOW: begin l.red_hw   = 1'b1; l.yellow_st = 1'b1; end
      default:   begin l.red_hw   = 1'b1; l.red_st    = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/smart_traffic_ctrl_gen2_seg7.sv
// seg7_decoder: BCD digit to 7-segment pattern.
//   bcd_i [3:0]  digit 0..9 (10..15 shown blank)
//   seg_o [6:0]  {g,f,e,d,c,b,a}, active-high
module seg7_decoder (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  import tlc_pkg::*;

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/smart_traffic_ctrl_gen2.sv
// smart_traffic_ctrl_gen2: highway/street traffic-light controller with street
// car-sensor demand, all-red clearance, street-green min/max limits and a
// two-digit countdown of the seconds left in the current phase.
// Ports:
//   clk, reset (async, active-high)
//   car_async                     street car sensor, asynchronous
//   red_hw/yellow_hw/green_hw     highway lamps (registered)
//   red_st/yellow_st/green_st     street lamps (registered)
//   seg_tens, seg_ones            countdown digits, {g,f,e,d,c,b,a} active-high
//   ped_req, walk                 only when TLC_PED_REQ_EN is defined
// Optional feature macro: TLC_PED_REQ_EN (pedestrian request + walk lamp).
module smart_traffic_ctrl_gen2 #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int HW_GREEN_MIN = 10,
  parameter int YELLOW_T     = 3,
  parameter int ALL_RED_T    = 1,
  parameter int ST_GREEN_MIN = 3,
  parameter int ST_GREEN_MAX = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_async,
`ifdef TLC_PED_REQ_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       red_hw,
  output logic       yellow_hw,
  output logic       green_hw,
  output logic       red_st,
  output logic       yellow_st,
  output logic       green_st,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);
  import tlc_pkg::*;

  localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]      HWG_LD     = 7'(HW_GREEN_MIN);
  localparam logic [6:0]      YEL_LD     = 7'(YELLOW_T);
  localparam logic [6:0]      AR_LD      = 7'(ALL_RED_T);
  localparam logic [6:0]      STG_LD     = 7'(ST_GREEN_MAX);
  // Street green may end early once at least ST_GREEN_MIN seconds have run,
  // i.e. once the countdown from ST_GREEN_MAX has reached this value.
  localparam logic [6:0]      ST_EARLY   = 7'(ST_GREEN_MAX - ST_GREEN_MIN + 1);

  logic          car_meta_q, car_s_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  phase_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  lamps_t        lamps_q;
  logic          ped_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_meta_q <= 1'b0;
      car_s_q    <= 1'b0;
    end else begin
      car_meta_q <= car_async;
      car_s_q    <= car_meta_q;
    end
  end

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

`ifdef TLC_PED_REQ_EN
  logic ped_meta_q, ped_s_q, ped_pend_q, walk_q;
  logic st_entry;

  assign st_entry = (state_d == ST_GREEN) && (state_q != ST_GREEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_meta_q <= 1'b0;
      ped_s_q    <= 1'b0;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_meta_q <= ped_req;
      ped_s_q    <= ped_meta_q;
      // Serving the street phase satisfies the request; a request still
      // held high re-latches on the following cycle.
      if (st_entry)     ped_pend_q <= 1'b0;
      else if (ped_s_q) ped_pend_q <= 1'b1;
      walk_q     <= (state_d == ST_GREEN);
    end
  end

  assign ped_pend = ped_pend_q;
  assign walk     = walk_q;
`else
  assign ped_pend = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HW_GREEN;
      cnt_q   <= HWG_LD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        HW_GREEN: begin
          if ((cnt_q <= 7'd1) && (car_s_q || ped_pend)) begin
            state_d = HW_YELLOW;
            cnt_d   = YEL_LD;
          end else if (cnt_q != 7'd0) begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        HW_YELLOW: begin
          if (cnt_q <= 7'd1) begin
            if (ALL_RED_T == 0) begin
              state_d = ST_GREEN;
              cnt_d   = STG_LD;
            end else begin
              state_d = AR1;
              cnt_d   = AR_LD;
            end
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        AR1: begin
          if (cnt_q <= 7'd1) begin
            state_d = ST_GREEN;
            cnt_d   = STG_LD;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        ST_GREEN: begin
          if ((cnt_q <= 7'd1) ||
              (!car_s_q && !ped_pend && (cnt_q <= ST_EARLY))) begin
            state_d = ST_YELLOW;
            cnt_d   = YEL_LD;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        ST_YELLOW: begin
          if (cnt_q <= 7'd1) begin
            if (ALL_RED_T == 0) begin
              state_d = HW_GREEN;
              cnt_d   = HWG_LD;
            end else begin
              state_d = AR2;
              cnt_d   = AR_LD;
            end
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        AR2: begin
          if (cnt_q <= 7'd1) begin
            state_d = HW_GREEN;
            cnt_d   = HWG_LD;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        default: begin
          state_d = HW_GREEN;
          cnt_d   = HWG_LD;
        end
      endcase
    end
  end

  // Lamps decode the next phase so the registered outputs line up with
  // state_q on every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lamps_q <= phase_lamps(HW_GREEN);
    else       lamps_q <= phase_lamps(state_d);
  end

  assign red_hw    = lamps_q.red_hw;
  assign yellow_hw = lamps_q.yellow_hw;
  assign green_hw  = lamps_q.green_hw;
  assign red_st    = lamps_q.red_st;
  assign yellow_st = lamps_q.yellow_st;
  assign green_st  = lamps_q.green_st;

  logic [6:0] tens_w, ones_w;

  assign tens_w = cnt_q / 7'd10;
  assign ones_w = cnt_q % 7'd10;

  seg7_decoder u_seg_tens (
    .bcd_i (tens_w[3:0]),
    .seg_o (seg_tens)
  );

  seg7_decoder u_seg_ones (
    .bcd_i (ones_w[3:0]),
    .seg_o (seg_ones)
  );

endmodule

// File: tb/tb_smart_traffic_ctrl_gen2.sv
// Bench for smart_traffic_ctrl_gen2: a short-timing build (ALL_RED_T=1) and a
// no-clearance build (ALL_RED_T=0) share clock, reset and car sensor.
// Expected lamp/countdown values are queued as each scenario is driven and
// compared one entry per tick.
module tb_smart_traffic_ctrl_gen2;

  localparam int TICK = 4;

  localparam logic [5:0] L_HWG = 6'b001100;
  localparam logic [5:0] L_HWY = 6'b010100;
  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_STG = 6'b100001;
  localparam logic [5:0] L_STY = 6'b100010;

  typedef struct {
    logic [5:0] lamps;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       car;
  logic [5:0] lamps_a, lamps_b;
  logic [6:0] tens_a, ones_a, tens_b, ones_b;
  logic       mon_en = 1'b0;

  int   total = 0;
  int   bad   = 0;
  int   tick_no = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  smart_traffic_ctrl_gen2 #(
    .TICK_DIV(4), .HW_GREEN_MIN(3), .YELLOW_T(2), .ALL_RED_T(1),
    .ST_GREEN_MIN(2), .ST_GREEN_MAX(5)
  ) u_dut (
    .clk(clk), .reset(reset), .car_async(car),
    .red_hw(lamps_a[5]), .yellow_hw(lamps_a[4]), .green_hw(lamps_a[3]),
    .red_st(lamps_a[2]), .yellow_st(lamps_a[1]), .green_st(lamps_a[0]),
    .seg_tens(tens_a), .seg_ones(ones_a)
  );

  smart_traffic_ctrl_gen2 #(
    .TICK_DIV(4), .HW_GREEN_MIN(3), .YELLOW_T(2), .ALL_RED_T(0),
    .ST_GREEN_MIN(2), .ST_GREEN_MAX(5)
  ) u_dut_nar (
    .clk(clk), .reset(reset), .car_async(car),
    .red_hw(lamps_b[5]), .yellow_hw(lamps_b[4]), .green_hw(lamps_b[3]),
    .red_st(lamps_b[2]), .yellow_st(lamps_b[1]), .green_st(lamps_b[0]),
    .seg_tens(tens_b), .seg_ones(ones_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] seg_of(input int c);
    return {dig(c / 10), dig(c % 10)};
  endfunction

  task automatic push_a(input logic [5:0] l, input int c);
    exp_t e;
    e.lamps = l; e.cnt = c;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [5:0] l, input int c);
    exp_t e;
    e.lamps = l; e.cnt = c;
    q_b.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check($sformatf("a_lamps@%0d", tick_no), 32'(lamps_a), 32'(e.lamps));
      check($sformatf("a_seg@%0d", tick_no), 32'({tens_a, ones_a}), 32'(seg_of(e.cnt)));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check($sformatf("b_lamps@%0d", tick_no), 32'(lamps_b), 32'(e.lamps));
      check($sformatf("b_seg@%0d", tick_no), 32'({tens_b, ones_b}), 32'(seg_of(e.cnt)));
    end
  endtask

  task automatic tick_check();
    repeat (TICK) @(posedge clk);
    #1;
    tick_no++;
    compare_now();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_lamps_a", 32'(lamps_a), 32'(L_HWG));
    check("rst_seg_a", 32'({tens_a, ones_a}), 32'(seg_of(3)));
    check("rst_lamps_b", 32'(lamps_b), 32'(L_HWG));
    @(negedge clk);
    reset = 1'b0;
    tick_no = 0;
  endtask

  // Exactly one lamp per road, every cycle, on both builds.
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot_hw_a", 32'($countones(lamps_a[5:3])), 32'd1);
      check("onehot_st_a", 32'($countones(lamps_a[2:0])), 32'd1);
      check("onehot_hw_b", 32'($countones(lamps_b[5:3])), 32'd1);
      check("onehot_st_b", 32'($countones(lamps_b[2:0])), 32'd1);
    end
  end

  initial begin
    reset = 1'b0;
    car   = 1'b0;
    #3 reset = 1'b1;
    #4 mon_en = 1'b1;

    // No street demand: highway green counts down to 0 and holds there.
    car = 1'b0;
    do_reset();
    push_a(L_HWG, 2);
    push_a(L_HWG, 1);
    for (int i = 0; i < 8; i++) push_a(L_HWG, 0);
    repeat (10) tick_check();

    // Car held: full cycle on both builds; the ALL_RED_T=0 build skips AR.
    car = 1'b1;
    do_reset();
    push_a(L_HWG, 2); push_a(L_HWG, 1);
    push_a(L_HWY, 2); push_a(L_HWY, 1);
    push_a(L_AR, 1);
    push_a(L_STG, 5); push_a(L_STG, 4); push_a(L_STG, 3); push_a(L_STG, 2); push_a(L_STG, 1);
    push_a(L_STY, 2); push_a(L_STY, 1);
    push_a(L_AR, 1);
    push_a(L_HWG, 3);
    push_b(L_HWG, 2); push_b(L_HWG, 1);
    push_b(L_HWY, 2); push_b(L_HWY, 1);
    push_b(L_STG, 5); push_b(L_STG, 4); push_b(L_STG, 3); push_b(L_STG, 2); push_b(L_STG, 1);
    push_b(L_STY, 2); push_b(L_STY, 1);
    push_b(L_HWG, 3); push_b(L_HWG, 2); push_b(L_HWG, 1);
    repeat (14) tick_check();

    // Car leaves right after street green starts: exit after the minimum.
    car = 1'b1;
    do_reset();
    push_a(L_HWG, 2); push_a(L_HWG, 1);
    push_a(L_HWY, 2); push_a(L_HWY, 1);
    push_a(L_AR, 1);
    push_a(L_STG, 5);
    repeat (6) tick_check();
    car = 1'b0;
    push_a(L_STG, 4);
    push_a(L_STY, 2); push_a(L_STY, 1);
    push_a(L_AR, 1);
    push_a(L_HWG, 3); push_a(L_HWG, 2);
    repeat (6) tick_check();

    // Car only around the HW_GREEN exit tick: sequence is still committed.
    car = 1'b0;
    do_reset();
    push_a(L_HWG, 2); push_a(L_HWG, 1);
    repeat (2) tick_check();
    car = 1'b1;
    push_a(L_HWY, 2);
    tick_check();
    car = 1'b0;
    push_a(L_HWY, 1);
    push_a(L_AR, 1);
    push_a(L_STG, 5); push_a(L_STG, 4);
    push_a(L_STY, 2); push_a(L_STY, 1);
    push_a(L_AR, 1);
    push_a(L_HWG, 3); push_a(L_HWG, 2);
    repeat (9) tick_check();

    // Reset in the middle of street green, then prescaler restarts from 0.
    car = 1'b1;
    do_reset();
    push_a(L_HWG, 2); push_a(L_HWG, 1);
    push_a(L_HWY, 2); push_a(L_HWY, 1);
    push_a(L_AR, 1);
    push_a(L_STG, 5); push_a(L_STG, 4);
    repeat (7) tick_check();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_lamps", 32'(lamps_a), 32'(L_HWG));
    check("midrst_seg", 32'({tens_a, ones_a}), 32'(seg_of(3)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (TICK - 1) @(posedge clk);
    #1;
    push_a(L_HWG, 3);
    compare_now();
    @(posedge clk);
    #1;
    push_a(L_HWG, 2);
    compare_now();

    check("q_a_empty", 32'(q_a.size()), 32'd0);
    check("q_b_empty", 32'(q_b.size()), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
